microwave_controller: RTL and testbench
=======================================

Name: microwave_controller

Overview:
- Sequencing FSM for the microwave countdown datapath: the seconds-units, seconds-tens and minutes digit counters, each with data/loadn/clrn/en/zero.
- Turns front-panel buttons and the door sensor into counter load, clear and enable strobes.
- Generates the 1 Hz count-enable, drives the magnetron, and times the end-of-cook beep.
- Sits between the debounced panel inputs and the counter chain.

Parameters:
CLK_DIV, 10, clk cycles per count tick (≥2); the bench uses 4
BEEP_TICKS, 3, number of ticks the beep stays on in DONE (≥1)

Ports:
clk  input  1  system clock
clrn  input  1  asynchronous active-low reset
startn  input  1  start button, active-low level, debounced and synchronous to clk
stopn  input  1  stop/pause button, active-low level, synchronous
clearn  input  1  clear button, active-low level, synchronous
load_req  input  1  keypad digit-entry strobe, one cycle high
door_closed  input  1  1 = door closed
zero  input  1  AND of all digit-counter zero flags; 1 = time remaining is 0
cnt_loadn  output  1  load strobe to all digit counters, active-low, one cycle
cnt_clrn  output  1  clear strobe to all digit counters, active-low, one cycle
cnt_en  output  1  decrement enable to the units counter, one-cycle pulse per tick
mag_on  output  1  magnetron drive
beep  output  1  buzzer drive
state  output  2  current state: 0 IDLE, 1 COOK, 2 PAUSE, 3 DONE

Behaviour:
- Reset: clrn low asynchronously forces state=IDLE, prescaler=0, beep counter=0, button history=1.
- Reset output values: cnt_loadn=1, cnt_clrn=1, cnt_en=0, mag_on=0, beep=0.
- All outputs are registered.
- Press detection: a press is detected on the edge where a button samples 0 and its previous sample was 1. Holding a button produces exactly one press.
- Priority when presses coincide: clear > stop > start.
- Strobes: cnt_loadn and cnt_clrn go low for exactly one cycle, in the cycle after the triggering event.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in COOK; a tick occurs at CLK_DIV-1, then it wraps to 0.
  - It is zeroed on every entry to COOK, so the first cnt_en arrives CLK_DIV cycles after the state changes to COOK.
  - It is zeroed when leaving COOK (pause discards the partial second).
- IDLE:
  - mag_on=0, beep=0.
  - load_req → cnt_loadn pulse.
  - Clear press → cnt_clrn pulse.
  - Start press with door_closed=1 and zero=0 → COOK.
  - Start press with zero=1 or door open is ignored.
- COOK:
  - mag_on=1; cnt_en pulses on each tick.
  - Clear press → IDLE plus cnt_clrn pulse.
  - Stop press → PAUSE.
  - zero=1 with no cnt_en pulse in the current or previous cycle (counter settled) → DONE.
  - load_req is ignored.
- PAUSE:
  - mag_on=0; counters hold their value.
  - Start press with door_closed=1 → COOK.
  - Stop or clear press → IDLE plus cnt_clrn pulse.
  - load_req is ignored.
- DONE:
  - mag_on=0, beep=1 for BEEP_TICKS×CLK_DIV cycles, then IDLE with beep=0.
  - Any button press ends DONE early → IDLE, beep=0 next cycle.
- mag_on is never 1 while door_closed=0 for more than one cycle (interlock; see the optional feature for the transition).
- Reset asserted mid-COOK: mag_on drops immediately (asynchronously). Counters are not cleared by this block.

Optional Feature:
- Macro: DOOR_INTERLOCK_EN.
- Defined:
  - door_closed=0 in COOK → PAUSE on the next edge, and mag_on drops next cycle.
  - Start is ignored while the door is open, in IDLE and in PAUSE.
- Not defined:
  - The door is checked only at start in IDLE.
  - Opening the door in COOK gates mag_on to 0 combinationally but the FSM stays in COOK and keeps counting.
  - Resume from PAUSE ignores door_closed.

Test Plan:
- CLK_DIV=4, counters loaded to 0:03, door closed, start press → 3 cnt_en pulses spaced 4 cycles apart, first 4 cycles after COOK entry, then DONE with beep high for 12 cycles, then IDLE.
- IDLE with zero=1, start press → state stays 0, mag_on stays 0.
- COOK at 0:05, stop press after 2 ticks → PAUSE, no cnt_en for 20 cycles; start press → COOK, next tick exactly 4 cycles later.
- COOK, stopn and clearn fall in the same cycle → IDLE, one cnt_clrn low pulse.
- DOOR_INTERLOCK_EN defined, door opens in COOK → PAUSE next edge, mag_on=0; start press with door open ignored; close door and press start → COOK.
- clrn asserted low mid-COOK → mag_on=0, state=0 immediately. Holding startn low across reset release produces no press.

Source files
------------

// File: rtl/microwave_controller.sv
// microwave_controller: sequencing FSM for the microwave countdown datapath.
// Turns panel buttons and the door sensor into load/clear/enable strobes
// for the digit-counter chain, generates the count tick, drives the
// magnetron and times the end-of-cook beep.
//
// Optional feature macro: DOOR_INTERLOCK_EN
//   defined   : opening the door in COOK pauses the cook; start is ignored
//               while the door is open (IDLE and PAUSE).
//   undefined : door is checked only at start from IDLE; opening the door in
//               COOK only gates mag_on_o, the FSM keeps counting.
module microwave_controller #(
    parameter int CLK_DIV    = 10,  // clk cycles per count tick (>= 2)
    parameter int BEEP_TICKS = 3    // ticks the beep stays on in DONE (>= 1)
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       startn_i,
    input  logic       stopn_i,
    input  logic       clearn_i,
    input  logic       load_req_i,
    input  logic       door_closed_i,
    input  logic       zero_i,
    output logic       cnt_loadn_o,
    output logic       cnt_clrn_o,
    output logic       cnt_en_o,
    output logic       mag_on_o,
    output logic       beep_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BEEP_CYCLES = BEEP_TICKS * CLK_DIV;
    localparam int PW          = $clog2(CLK_DIV);
    localparam int BW          = $clog2(BEEP_CYCLES);

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
    logic            startn_q, stopn_q, clearn_q;
    logic            hist_vld_q;
    logic            cnt_loadn_q, cnt_loadn_d;
    logic            cnt_clrn_q, cnt_clrn_d;
    logic            cnt_en_q, cnt_en_d;
    logic            en_prev_q;
    logic            mag_on_q, mag_on_d;
    logic            beep_q, beep_d;

    // Falling-edge press detection. hist_vld_q masks the first sample after
    // reset so a button held across reset release never counts as a press.
    logic start_press, stop_press, clear_press;
    logic start_p, stop_p, clear_p, any_press;
    logic resume_ok;

    assign start_press = hist_vld_q & startn_q & ~startn_i;
    assign stop_press  = hist_vld_q & stopn_q  & ~stopn_i;
    assign clear_press = hist_vld_q & clearn_q & ~clearn_i;

    // Coincident presses resolve as clear > stop > start.
    assign clear_p   = clear_press;
    assign stop_p    = stop_press  & ~clear_press;
    assign start_p   = start_press & ~stop_press & ~clear_press;
    assign any_press = start_press | stop_press | clear_press;

`ifdef DOOR_INTERLOCK_EN
    assign resume_ok = door_closed_i;
`else
    assign resume_ok = 1'b1;
`endif

    // State, prescaler, button history and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            beep_cnt_q  <= '0;
            startn_q    <= 1'b1;
            stopn_q     <= 1'b1;
            clearn_q    <= 1'b1;
            hist_vld_q  <= 1'b0;
            cnt_loadn_q <= 1'b1;
            cnt_clrn_q  <= 1'b1;
            cnt_en_q    <= 1'b0;
            en_prev_q   <= 1'b0;
            mag_on_q    <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            beep_cnt_q  <= beep_cnt_d;
            startn_q    <= startn_i;
            stopn_q     <= stopn_i;
            clearn_q    <= clearn_i;
            hist_vld_q  <= 1'b1;
            cnt_loadn_q <= cnt_loadn_d;
            cnt_clrn_q  <= cnt_clrn_d;
            cnt_en_q    <= cnt_en_d;
            en_prev_q   <= cnt_en_q;
            mag_on_q    <= mag_on_d;
            beep_q      <= beep_d;
        end
    end

    // Next-state and next-output logic.
    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        presc_d     = '0;
        beep_cnt_d  = '0;
        cnt_loadn_d = 1'b1;
        cnt_clrn_d  = 1'b1;
        cnt_en_d    = 1'b0;
        beep_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_req_i) cnt_loadn_d = 1'b0;
                if (clear_p) begin
                    cnt_clrn_d = 1'b0;
                end else if (start_p && door_closed_i && !zero_i) begin
                    state_d = COOK;
                end
            end
            COOK: begin
                if (clear_p) begin
                    state_d    = IDLE;
                    cnt_clrn_d = 1'b0;
                end else if (stop_p) begin
                    state_d = PAUSE;
`ifdef DOOR_INTERLOCK_EN
                end else if (!door_closed_i) begin
                    state_d = PAUSE;
`endif
                end else if (zero_i && !cnt_en_q && !en_prev_q) begin
                    // Counter chain has settled at zero: start the beep.
                    state_d = DONE;
                    beep_d  = 1'b1;
                end else if (presc_q == PW'(CLK_DIV - 1)) begin
                    // Never decrement past zero while the chain settles.
                    cnt_en_d = !zero_i;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSE: begin
                if (clear_p || stop_p) begin
                    state_d    = IDLE;
                    cnt_clrn_d = 1'b0;
                end else if (start_p && resume_ok) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (any_press || beep_cnt_q == BW'(BEEP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                    beep_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mag_on_d    = (state_d == COOK);
    assign cnt_loadn_o = cnt_loadn_q;
    assign cnt_clrn_o  = cnt_clrn_q;
    assign cnt_en_o    = cnt_en_q;
    assign beep_o      = beep_q;
    assign state_o     = state_q;

`ifdef DOOR_INTERLOCK_EN
    assign mag_on_o = mag_on_q;
`else
    // Door open mid-cook cuts the magnetron at once; the FSM keeps counting.
    assign mag_on_o = mag_on_q & door_closed_i;
`endif

endmodule

// File: tb/tb_microwave_controller.sv
// tb_microwave_controller: directed stimulus; expected output events are
// queued by the stimulus and consumed by an independent monitor that reports
// every change on the DUT outputs. A small counter-chain model supplies zero.
module tb_microwave_controller;

    localparam int CLK_DIV    = 4;
    localparam int BEEP_TICKS = 3;
    localparam int BEEP_LEN   = CLK_DIV * BEEP_TICKS;

    typedef enum int {
        EV_STATE = 0,
        EV_MAG   = 1,
        EV_BEEP  = 2,
        EV_EN    = 3,
        EV_CLR   = 4,
        EV_LOAD  = 5
    } ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       val;
        int       cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  mon_en = 1'b0;

    logic       clk;
    logic       clrn;
    logic       startn, stopn, clearn, load_req, door_closed;
    logic       zero;
    logic       cnt_loadn, cnt_clrn, cnt_en, mag_on, beep;
    logic [1:0] state;

    int rem      = 0;
    int load_val = 0;

    assign zero = (rem == 0);

    microwave_controller #(
        .CLK_DIV   (CLK_DIV),
        .BEEP_TICKS(BEEP_TICKS)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .startn_i     (startn),
        .stopn_i      (stopn),
        .clearn_i     (clearn),
        .load_req_i   (load_req),
        .door_closed_i(door_closed),
        .zero_i       (zero),
        .cnt_loadn_o  (cnt_loadn),
        .cnt_clrn_o   (cnt_clrn),
        .cnt_en_o     (cnt_en),
        .mag_on_o     (mag_on),
        .beep_o       (beep),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Digit-counter chain model: total seconds remaining.
    always @(posedge clk) begin
        if (!cnt_loadn)               rem <= load_val;
        else if (!cnt_clrn)           rem <= 0;
        else if (cnt_en && rem > 0)   rem <= rem - 1;
    end

    // ---------------- scoreboard ----------------
    function automatic void expect_ev(input ev_kind_e k, input int v, input int c);
        ev_t e;
        int  i;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= k)))
            i++;
        exp_q.insert(i, e);
    endfunction

    function automatic void expect_pulse(input ev_kind_e k, input int c);
        if (k == EV_EN) begin
            expect_ev(k, 1, c);
            expect_ev(k, 0, c + 1);
        end else begin
            expect_ev(k, 0, c);
            expect_ev(k, 1, c + 1);
        end
    endfunction

    // Full cook of n ticks after a start tap driven at cycle t.
    function automatic void expect_cook_run(input int t, input int n);
        int e0;
        int d;
        e0 = t + 1;
        d  = e0 + CLK_DIV * n + 3;
        expect_ev(EV_STATE, 1, e0);
        expect_ev(EV_MAG, 1, e0);
        for (int k = 1; k <= n; k++) expect_pulse(EV_EN, e0 + CLK_DIV * k);
        expect_ev(EV_STATE, 3, d);
        expect_ev(EV_MAG, 0, d);
        expect_ev(EV_BEEP, 1, d);
        expect_ev(EV_STATE, 0, d + BEEP_LEN);
        expect_ev(EV_BEEP, 0, d + BEEP_LEN);
    endfunction

    task automatic observe(input ev_kind_e k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got value %0d at cycle %0d, required no event",
                     k.name(), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                         e.kind.name(), k.name(), v, cyc, e.kind.name(), e.val, e.cyc);
            end
        end
    endtask

    logic [1:0] p_state;
    logic       p_mag, p_beep, p_en, p_clr, p_load;

    // Monitor: report every output change, sampled away from the clock edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (state     != p_state) observe(EV_STATE, int'(state));
            if (mag_on    != p_mag)   observe(EV_MAG,   int'(mag_on));
            if (beep      != p_beep)  observe(EV_BEEP,  int'(beep));
            if (cnt_en    != p_en)    observe(EV_EN,    int'(cnt_en));
            if (cnt_clrn  != p_clr)   observe(EV_CLR,   int'(cnt_clrn));
            if (cnt_loadn != p_load)  observe(EV_LOAD,  int'(cnt_loadn));
        end
        p_state <= state;
        p_mag   <= mag_on;
        p_beep  <= beep;
        p_en    <= cnt_en;
        p_clr   <= cnt_clrn;
        p_load  <= cnt_loadn;
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic tap(input bit s, input bit p, input bit c);
        startn = ~s;
        stopn  = ~p;
        clearn = ~c;
        step();
        startn = 1'b1;
        stopn  = 1'b1;
        clearn = 1'b1;
    endtask

    task automatic do_load(input int v);
        load_val = v;
        expect_pulse(EV_LOAD, cyc + 1);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        step();
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int t;
        int p;
        int v;
        clrn        = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        load_req    = 1'b0;
        door_closed = 1'b1;
        steps(2);

        check("reset_state",     int'(state),     0);
        check("reset_mag_on",    int'(mag_on),    0);
        check("reset_beep",      int'(beep),      0);
        check("reset_cnt_en",    int'(cnt_en),    0);
        check("reset_cnt_loadn", int'(cnt_loadn), 1);
        check("reset_cnt_clrn",  int'(cnt_clrn),  1);

        clrn = 1'b1;
        steps(2);
        mon_en = 1'b1;

        // Clear in IDLE: single clear strobe.
        t = cyc;
        expect_pulse(EV_CLR, t + 1);
        tap(1'b0, 1'b0, 1'b1);
        steps(2);

        // Start with zero=1 is ignored.
        tap(1'b1, 1'b0, 1'b0);
        steps(3);
        check("zero_start_state",  int'(state),  0);
        check("zero_start_mag_on", int'(mag_on), 0);

        // Full cook from 0:03 through the beep back to IDLE.
        do_load(3);
        step();
        t = cyc;
        expect_cook_run(t, 3);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(t + 32);
        check("run3_remaining", rem, 0);

        // Pause after two ticks, resume, then stop+clear together.
        do_load(5);
        step();
        t = cyc;
        expect_ev(EV_STATE, 1, t + 1);
        expect_ev(EV_MAG, 1, t + 1);
        expect_pulse(EV_EN, t + 5);
        expect_pulse(EV_EN, t + 9);
        expect_ev(EV_STATE, 2, t + 11);
        expect_ev(EV_MAG, 0, t + 11);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(t + 10);
        tap(1'b0, 1'b1, 1'b0);
        steps(20);
        check("pause_remaining", rem, 3);
        p = cyc;
        expect_ev(EV_STATE, 1, p + 1);
        expect_ev(EV_MAG, 1, p + 1);
        expect_pulse(EV_EN, p + 5);
        expect_ev(EV_STATE, 0, p + 7);
        expect_ev(EV_MAG, 0, p + 7);
        expect_pulse(EV_CLR, p + 7);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(p + 6);
        tap(1'b0, 1'b1, 1'b1);
        steps(3);
        check("stopclear_remaining", rem, 0);

        // DONE ended early by a button press.
        do_load(1);
        step();
        t = cyc;
        expect_ev(EV_STATE, 1, t + 1);
        expect_ev(EV_MAG, 1, t + 1);
        expect_pulse(EV_EN, t + 5);
        expect_ev(EV_STATE, 3, t + 8);
        expect_ev(EV_MAG, 0, t + 8);
        expect_ev(EV_BEEP, 1, t + 8);
        expect_ev(EV_STATE, 0, t + 11);
        expect_ev(EV_BEEP, 0, t + 11);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(t + 10);
        tap(1'b0, 1'b0, 1'b1);
        steps(3);

        // Start with the door open in IDLE is ignored.
        do_load(2);
        door_closed = 1'b0;
        tap(1'b1, 1'b0, 1'b0);
        steps(3);
        check("door_open_start_state", int'(state), 0);
        door_closed = 1'b1;
        step();

`ifdef DOOR_INTERLOCK_EN
        // Door opens mid-cook: pause next edge; start ignored until closed.
        t = cyc;
        expect_ev(EV_STATE, 1, t + 1);
        expect_ev(EV_MAG, 1, t + 1);
        expect_ev(EV_STATE, 2, t + 3);
        expect_ev(EV_MAG, 0, t + 3);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(t + 2);
        door_closed = 1'b0;
        steps(3);
        tap(1'b1, 1'b0, 1'b0);
        steps(3);
        check("interlock_pause_state", int'(state), 2);
        door_closed = 1'b1;
        step();
        v = cyc;
        expect_cook_run(v, 2);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(v + 27);
`else
        // Door opens mid-cook: magnetron gated, counting continues.
        t = cyc;
        expect_ev(EV_STATE, 1, t + 1);
        expect_ev(EV_MAG, 1, t + 1);
        expect_ev(EV_MAG, 0, t + 3);
        expect_pulse(EV_EN, t + 5);
        expect_ev(EV_MAG, 1, t + 7);
        expect_pulse(EV_EN, t + 9);
        expect_ev(EV_STATE, 3, t + 12);
        expect_ev(EV_MAG, 0, t + 12);
        expect_ev(EV_BEEP, 1, t + 12);
        expect_ev(EV_STATE, 0, t + 12 + BEEP_LEN);
        expect_ev(EV_BEEP, 0, t + 12 + BEEP_LEN);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(t + 2);
        door_closed = 1'b0;
        wait_until(t + 6);
        door_closed = 1'b1;
        wait_until(t + 27);
        v = cyc;
`endif
        check("door_run_remaining", rem, 0);

        // Reset mid-cook with start held across reset release.
        do_load(3);
        step();
        t = cyc;
        expect_ev(EV_STATE, 1, t + 1);
        expect_ev(EV_MAG, 1, t + 1);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(t + 3);
        check("precook_mag_on", int'(mag_on), 1);
        mon_en = 1'b0;
        clrn   = 1'b0;
        startn = 1'b0;
        #1;
        check("async_reset_state",  int'(state),  0);
        check("async_reset_mag_on", int'(mag_on), 0);
        steps(2);
        clrn = 1'b1;
        step();
        mon_en = 1'b1;
        steps(6);
        startn = 1'b1;
        steps(2);
        check("held_start_state", int'(state), 0);
        check("reset_keeps_counters", rem, 3);

        // Fresh start after reset, then clear out of COOK.
        t = cyc;
        expect_ev(EV_STATE, 1, t + 1);
        expect_ev(EV_MAG, 1, t + 1);
        expect_ev(EV_STATE, 0, t + 4);
        expect_ev(EV_MAG, 0, t + 4);
        expect_pulse(EV_CLR, t + 4);
        tap(1'b1, 1'b0, 1'b0);
        wait_until(t + 3);
        tap(1'b0, 1'b0, 1'b1);
        steps(5);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_%s: got no event, required value %0d at cycle %0d",
                     e.kind.name(), e.val, e.cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
